// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: registered CPU data-access sequencer. One request at a
// time; flags exception-return and misaligned addresses, drives a req/ack bus
// with byte lanes and a timeout, returns a one-cycle response.
// Ports: clk_i/rst_n_i; req_valid_i/req_ready_o, rw_i, byte_access_i, addr_i,
// wdata_i (request); mem_req_o/mem_ack_i, mem_rw_o, mem_addr_o, mem_be_o,
// mem_wdata_o, mem_rdata_i (bus); rsp_valid_o, rdata_o, bad_addr_o, exc_ret_o,
// bus_err_o (response). Macro MISALIGN_SPLIT_EN: misaligned words run 2 beats.
module mem_access_sequencer #(
  parameter int WORD = 16,
  parameter int ADDR = 16,
  parameter logic [ADDR-1:0] EXC_RET = ADDR'(16'hFFFF),
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              rw_i,
  input  logic              byte_access_i,
  input  logic [ADDR-1:0]   addr_i,
  input  logic [WORD-1:0]   wdata_i,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  output logic              mem_rw_o,
  output logic [ADDR-1:0]   mem_addr_o,
  output logic [WORD/8-1:0] mem_be_o,
  output logic [WORD-1:0]   mem_wdata_o,
  input  logic [WORD-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [WORD-1:0]   rdata_o,
  output logic              bad_addr_o,
  output logic              exc_ret_o,
  output logic              bus_err_o
);
  localparam int LANES = WORD / 8;
  localparam int OFS = $clog2(LANES);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LANES-1:0] ALL = '1;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, ISSUE2, RESP} state_t;

  state_t state_q, state_d;
  logic rw_q, rw_d, byte_q, byte_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic ready_q, ready_d;
  logic mreq_q, mreq_d, mrw_q, mrw_d;
  logic [ADDR-1:0] maddr_q, maddr_d;
  logic [LANES-1:0] be_q, be_d;
  logic [WORD-1:0] mwd_q, mwd_d;
  logic rsp_q, rsp_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic bad_q, bad_d, exc_q, exc_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef MISALIGN_SPLIT_EN
  logic [WORD-1:0] rbuf_q, rbuf_d;
`endif

  logic [OFS-1:0] ofs;
  logic mis, expire;
  logic [WORD-1:0] rd_val;

  assign ofs = addr_q[OFS-1:0];
  assign mis = !byte_q && (ofs != '0);
  assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  function automatic logic [WORD-1:0] lane_byte(
    input logic [WORD-1:0] d, input logic [OFS-1:0] o);
    logic [WORD-1:0] t;
    t = d >> {o, 3'b000};
    return {{(WORD-8){1'b0}}, t[7:0]};
  endfunction

`ifdef MISALIGN_SPLIT_EN
  function automatic logic [WORD-1:0] rotl(
    input logic [WORD-1:0] d, input logic [OFS-1:0] o);
    logic [2*WORD-1:0] t;
    t = {d, d} << {o, 3'b000};
    return t[2*WORD-1:WORD];
  endfunction

  function automatic logic [WORD-1:0] rotr(
    input logic [WORD-1:0] d, input logic [OFS-1:0] o);
    logic [2*WORD-1:0] t;
    t = {d, d} >> {o, 3'b000};
    return t[WORD-1:0];
  endfunction

  // beat 1 owns lanes >= o, beat 2 owns lanes < o
  function automatic logic [WORD-1:0] merge(
    input logic [WORD-1:0] hi, input logic [WORD-1:0] lo,
    input logic [OFS-1:0] o);
    logic [WORD-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = (k >= int'(o)) ? hi[8*k +: 8] : lo[8*k +: 8];
    return r;
  endfunction

  assign rd_val = rw_q ? '0 :
    mis ? rotr(merge(rbuf_q, mem_rdata_i, ofs), ofs) :
    byte_q ? lane_byte(mem_rdata_i, ofs) : mem_rdata_i;
`else
  assign rd_val = rw_q ? '0 :
    byte_q ? lane_byte(mem_rdata_i, ofs) : mem_rdata_i;
`endif

  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    byte_d = byte_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    mreq_d = mreq_q;
    mrw_d = mrw_q;
    maddr_d = maddr_q;
    be_d = be_q;
    mwd_d = mwd_q;
    rsp_d = 1'b0;
    rdata_d = rdata_q;
    bad_d = 1'b0;
    exc_d = 1'b0;
    err_d = 1'b0;
    cnt_d = cnt_q;
`ifdef MISALIGN_SPLIT_EN
    rbuf_d = rbuf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rw_d = rw_i;
          byte_d = byte_access_i;
          addr_d = addr_i;
          wdata_d = wdata_i;
          ready_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (addr_q == EXC_RET) begin
          state_d = RESP;
          rsp_d = 1'b1;
          exc_d = 1'b1;
          rdata_d = '0;
        end
`ifndef MISALIGN_SPLIT_EN
        else if (mis) begin
          state_d = RESP;
          rsp_d = 1'b1;
          bad_d = 1'b1;
          rdata_d = '0;
        end
`endif
        else begin
          state_d = ISSUE;
          mreq_d = 1'b1;
          mrw_d = rw_q;
          maddr_d = {addr_q[ADDR-1:OFS], {OFS{1'b0}}};
          cnt_d = '0;
          if (byte_q) begin
            be_d = LANES'(1) << ofs;
            mwd_d = {LANES{wdata_q[7:0]}};
          end else begin
`ifdef MISALIGN_SPLIT_EN
            be_d = ALL << ofs;
            mwd_d = rotl(wdata_q, ofs);
`else
            be_d = ALL;
            mwd_d = wdata_q;
`endif
          end
        end
      end
      ISSUE: begin
        if (mem_ack_i) begin
`ifdef MISALIGN_SPLIT_EN
          if (mis) begin
            state_d = ISSUE2;
            rbuf_d = mem_rdata_i;
            maddr_d = maddr_q + ADDR'(LANES);
            be_d = ~(ALL << ofs);
            cnt_d = '0;
          end else
`endif
          begin
            state_d = RESP;
            mreq_d = 1'b0;
            rsp_d = 1'b1;
            rdata_d = rd_val;
          end
        end else if (expire) begin
          state_d = RESP;
          mreq_d = 1'b0;
          rsp_d = 1'b1;
          err_d = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ISSUE2: begin
        if (mem_ack_i) begin
          state_d = RESP;
          mreq_d = 1'b0;
          rsp_d = 1'b1;
          rdata_d = rd_val;
        end else if (expire) begin
          state_d = RESP;
          mreq_d = 1'b0;
          rsp_d = 1'b1;
          err_d = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      byte_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      mreq_q <= 1'b0;
      mrw_q <= 1'b0;
      maddr_q <= '0;
      be_q <= '0;
      mwd_q <= '0;
      rsp_q <= 1'b0;
      rdata_q <= '0;
      bad_q <= 1'b0;
      exc_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      rbuf_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      byte_q <= byte_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      mreq_q <= mreq_d;
      mrw_q <= mrw_d;
      maddr_q <= maddr_d;
      be_q <= be_d;
      mwd_q <= mwd_d;
      rsp_q <= rsp_d;
      rdata_q <= rdata_d;
      bad_q <= bad_d;
      exc_q <= exc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
`ifdef MISALIGN_SPLIT_EN
      rbuf_q <= rbuf_d;
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign mem_req_o = mreq_q;
  assign mem_rw_o = mrw_q;
  assign mem_addr_o = maddr_q;
  assign mem_be_o = be_q;
  assign mem_wdata_o = mwd_q;
  assign rsp_valid_o = rsp_q;
  assign rdata_o = rdata_q;
  assign bad_addr_o = bad_q;
  assign exc_ret_o = exc_q;
  assign bus_err_o = err_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: vector table, hand sequences and random accesses
// checked against a byte-array memory model of the access rules.
module tb_mem_access_sequencer;
  localparam int TO = 15;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, rw = 1'b0, byt = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic req_ready_o, mem_req_o, mem_rw_o, rsp_valid_o;
  logic bad_addr_o, exc_ret_o, bus_err_o;
  logic [15:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic [1:0] mem_be_o;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] bmem [65536];
  logic [7:0] mmem [65536];

  typedef struct {
    logic rsp;
    logic [15:0] rdata;
    logic [2:0] flg;
    int lat;
    int reqc;
    int beats;
    logic sp;
    logic [15:0] a0, a1, wd0, wd1;
    logic [1:0] be0, be1;
  } res_t;

  typedef struct {
    logic rw, byt;
    logic [15:0] addr, wd;
    int dly;
    res_t e;
  } vec_t;

  mem_access_sequencer #(
    .WORD(16), .ADDR(16), .EXC_RET(16'hFFFF), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .rw_i(rw), .byte_access_i(byt), .addr_i(addr), .wdata_i(wdata),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack), .mem_rw_o(mem_rw_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o),
    .bad_addr_o(bad_addr_o), .exc_ret_o(exc_ret_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: access rules applied to a byte array, no cycle-level state.
  task automatic model(input logic w, input logic b,
                       input logic [15:0] a, input logic [15:0] d,
                       input int dly, output res_t e);
    logic [15:0] base, a1;
    e = '{default: 0};
    e.rsp = 1'b1;
    base = a & 16'hFFFE;
    a1 = a + 16'd1;
    if (a == 16'hFFFF) begin
      e.flg = 3'b010;
      e.lat = 2;
    end else if (!b && a[0] && !SPLIT) begin
      e.flg = 3'b100;
      e.lat = 2;
    end else begin
      e.sp = !b && a[0];
      e.a0 = base;
      e.a1 = base + 16'd2;
      e.be0 = b ? (a[0] ? 2'b10 : 2'b01) : (e.sp ? 2'b10 : 2'b11);
      e.be1 = 2'b01;
      e.wd0 = b ? {d[7:0], d[7:0]} : (e.sp ? {d[7:0], d[15:8]} : d);
      e.wd1 = e.wd0;
      if (dly >= TO) begin
        e.flg = 3'b001;
        e.lat = 2 + TO;
        e.reqc = TO;
        e.sp = 1'b0;
      end else begin
        e.lat = e.sp ? 4 + 2 * dly : 3 + dly;
        e.reqc = e.sp ? 2 * (dly + 1) : dly + 1;
        if (w) begin
          mmem[a] = d[7:0];
          if (!b) mmem[a1] = d[15:8];
        end else begin
          e.rdata = b ? {8'h00, mmem[a]} : {mmem[a1], mmem[a]};
        end
      end
    end
  endtask

  // Drives one request and acts as the bus slave; ack after dly waits/beat.
  task automatic run_access(input logic w, input logic b,
                            input logic [15:0] a, input logic [15:0] d,
                            input int dly, output res_t o);
    int t, wt;
    bit done;
    logic [15:0] ba, ba1;
    o = '{default: 0};
    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid = 1'b1;
    rw = w;
    byt = b;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t = 1;
    wt = 0;
    done = 1'b0;
    while (!done && t < 100) begin
      mem_ack = 1'b0;
      if (rsp_valid_o) begin
        o.rsp = 1'b1;
        o.rdata = rdata_o;
        o.flg = {bad_addr_o, exc_ret_o, bus_err_o};
        o.lat = t;
        done = 1'b1;
      end else if (mem_req_o) begin
        o.reqc++;
        if (wt == 0 && o.beats == 0) begin
          o.a0 = mem_addr_o; o.be0 = mem_be_o; o.wd0 = mem_wdata_o;
        end else if (wt == 0 && o.beats == 1) begin
          o.a1 = mem_addr_o; o.be1 = mem_be_o; o.wd1 = mem_wdata_o;
        end
        if (wt == dly) begin
          ba = mem_addr_o;
          ba1 = ba + 16'd1;
          mem_ack = 1'b1;
          mem_rdata = {bmem[ba1], bmem[ba]};
          if (mem_rw_o) begin
            if (mem_be_o[0]) bmem[ba] = mem_wdata_o[7:0];
            if (mem_be_o[1]) bmem[ba1] = mem_wdata_o[15:8];
          end
          o.beats++;
          wt = 0;
        end else begin
          wt++;
        end
      end
      if (!done) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_wait: got no rsp_valid_o required rsp within 100 cycles");
    end
    @(posedge clk);
    #1;
    chk("ready_after", {31'd0, req_ready_o}, 32'd1);
  endtask

  task automatic check_res(input string tag, input res_t o, input res_t e,
                           input logic w);
    chk({tag, ".rsp"}, {31'd0, o.rsp}, {31'd0, e.rsp});
    chk({tag, ".rdata"}, {16'd0, o.rdata}, {16'd0, e.rdata});
    chk({tag, ".flags"}, {29'd0, o.flg}, {29'd0, e.flg});
    chk({tag, ".lat"}, o.lat, e.lat);
    chk({tag, ".reqc"}, o.reqc, e.reqc);
    if (e.reqc > 0) begin
      chk({tag, ".addr0"}, {16'd0, o.a0}, {16'd0, e.a0});
      chk({tag, ".be0"}, {30'd0, o.be0}, {30'd0, e.be0});
      if (w) chk({tag, ".wd0"}, {16'd0, o.wd0}, {16'd0, e.wd0});
    end
    if (e.sp) begin
      chk({tag, ".addr1"}, {16'd0, o.a1}, {16'd0, e.a1});
      chk({tag, ".be1"}, {30'd0, o.be1}, {30'd0, e.be1});
    end
  endtask

  function automatic vec_t mk(input logic w, input logic b,
    input logic [15:0] a, input logic [15:0] d, input int dly,
    input logic [15:0] rd, input logic [2:0] flg, input int lat,
    input int reqc, input logic [15:0] a0, input logic [1:0] be0,
    input logic [15:0] wd0);
    vec_t v;
    v.rw = w; v.byt = b; v.addr = a; v.wd = d; v.dly = dly;
    v.e = '{default: 0};
    v.e.rsp = 1'b1; v.e.rdata = rd; v.e.flg = flg; v.e.lat = lat;
    v.e.reqc = reqc; v.e.a0 = a0; v.e.be0 = be0; v.e.wd0 = wd0;
    return v;
  endfunction

  vec_t vt [14];

  initial begin
    res_t o, e;
    int cnt;
    logic r_w, r_b;
    logic [15:0] r_a, r_d;
    int r_dly, sel;

    for (int i = 0; i < 65536; i++) begin
      bmem[i] = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    bmem[16'h0010] = 8'hEF; bmem[16'h0011] = 8'hBE;
    mmem[16'h0010] = 8'hEF; mmem[16'h0011] = 8'hBE;

    vt[0] = mk(0, 0, 16'h0010, 16'h0000, 2, 16'hBEEF, 3'b000, 5, 3, 16'h0010, 2'b11, 16'h0);
    vt[1] = mk(1, 1, 16'h0013, 16'h00A5, 0, 16'h0000, 3'b000, 3, 1, 16'h0012, 2'b10, 16'hA5A5);
`ifdef MISALIGN_SPLIT_EN
    vt[2] = mk(0, 0, 16'h0013, 16'h0000, 0, 16'h4EA5, 3'b000, 4, 2, 16'h0012, 2'b10, 16'h0);
`else
    vt[2] = mk(0, 0, 16'h0013, 16'h0000, 0, 16'h0000, 3'b100, 2, 0, 16'h0, 2'b00, 16'h0);
`endif
    vt[3] = mk(0, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 3'b010, 2, 0, 16'h0, 2'b00, 16'h0);
    vt[4] = mk(0, 1, 16'hFFFF, 16'h0000, 0, 16'h0000, 3'b010, 2, 0, 16'h0, 2'b00, 16'h0);
    vt[5] = mk(1, 0, 16'hFFFF, 16'h1111, 0, 16'h0000, 3'b010, 2, 0, 16'h0, 2'b00, 16'h0);
    vt[6] = mk(0, 0, 16'h0020, 16'h0000, 1000, 16'h0000, 3'b001, 17, 15, 16'h0020, 2'b11, 16'h0);
    vt[7] = mk(0, 1, 16'h0013, 16'h0000, 0, 16'h00A5, 3'b000, 3, 1, 16'h0012, 2'b10, 16'h0);
    vt[8] = mk(0, 1, 16'h0012, 16'h0000, 1, 16'h0048, 3'b000, 4, 2, 16'h0012, 2'b01, 16'h0);
    vt[9] = mk(1, 0, 16'h0030, 16'hC0DE, 0, 16'h0000, 3'b000, 3, 1, 16'h0030, 2'b11, 16'hC0DE);
    vt[10] = mk(0, 0, 16'h0030, 16'h0000, 3, 16'hC0DE, 3'b000, 6, 4, 16'h0030, 2'b11, 16'h0);
    vt[11] = mk(0, 0, 16'h0010, 16'h0000, 14, 16'hBEEF, 3'b000, 17, 15, 16'h0010, 2'b11, 16'h0);
    vt[12] = mk(1, 1, 16'h0031, 16'h0077, 1000, 16'h0000, 3'b001, 17, 15, 16'h0030, 2'b10, 16'h7777);
    vt[13] = mk(0, 0, 16'h0030, 16'h0000, 0, 16'hC0DE, 3'b000, 3, 1, 16'h0030, 2'b11, 16'h0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw_o}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr_o}, 32'd0);
    chk("rst_mem_be", {30'd0, mem_be_o}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata_o}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_o}, 32'd0);
    chk("rst_flags", {29'd0, bad_addr_o, exc_ret_o, bus_err_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      model(vt[i].rw, vt[i].byt, vt[i].addr, vt[i].wd, vt[i].dly, e);
      run_access(vt[i].rw, vt[i].byt, vt[i].addr, vt[i].wd, vt[i].dly, o);
      check_res($sformatf("vec%0d", i), o, vt[i].e, vt[i].rw);
    end

`ifdef MISALIGN_SPLIT_EN
    model(1'b1, 1'b0, 16'h0021, 16'h1234, 0, e);
    run_access(1'b1, 1'b0, 16'h0021, 16'h1234, 0, o);
    chk("split_a0", {16'd0, o.a0}, 32'h0020);
    chk("split_be0", {30'd0, o.be0}, 32'h2);
    chk("split_wd0", {16'd0, o.wd0}, 32'h3412);
    chk("split_a1", {16'd0, o.a1}, 32'h0022);
    chk("split_be1", {30'd0, o.be1}, 32'h1);
    chk("split_wd1", {16'd0, o.wd1}, 32'h3412);
    chk("split_flags", {29'd0, o.flg}, 32'd0);
    chk("split_lat", o.lat, 4);
    model(1'b0, 1'b0, 16'h0021, 16'h0000, 1, e);
    run_access(1'b0, 1'b0, 16'h0021, 16'h0000, 1, o);
    chk("split_rd", {16'd0, o.rdata}, 32'h1234);
    chk("split_rd_lat", o.lat, 6);
`endif

    // reset in the middle of a bus cycle
    req_valid = 1'b1; rw = 1'b0; byt = 1'b0; addr = 16'h0040;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_req_before", {31'd0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o || mem_req_o) cnt++;
    end
    chk("midrst_quiet", cnt, 0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) r_a = 16'hFFFF;
      else if (sel == 1) r_a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else r_a = 16'($urandom_range(0, 63));
      r_w = 1'($urandom_range(0, 1));
      r_b = 1'($urandom_range(0, 1));
      r_d = 16'($urandom);
      r_dly = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 3);
      model(r_w, r_b, r_a, r_d, r_dly, e);
      run_access(r_w, r_b, r_a, r_d, r_dly, o);
      check_res($sformatf("rnd%0d", i), o, e, r_w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
